// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides.
// Optional almost-full/almost-empty flags are compiled in with SYNC_FIFO_ALMOST_EN.
module sync_fifo #(
   parameter int ADDRW = 4,
   parameter int DATAW = 8
`ifdef SYNC_FIFO_ALMOST_EN
   ,
   parameter int AF_LEVEL = (2 ** ADDRW) - 2,
   parameter int AE_LEVEL = 2
`endif
) (
   input  logic             clk,
   input  logic             rst,
   // A word moves on a rising edge only when valid and ready are both high;
   // ready/valid outputs depend on registered state only, never on the peer's inputs.
   input  logic             i_wr_valid,
   output logic             o_wr_ready,
   input  logic [DATAW-1:0] i_wr_data,
   output logic             o_rd_valid,
   input  logic             i_rd_ready,
   output logic [DATAW-1:0] o_rd_data,
   output logic [ADDRW:0]   o_count
`ifdef SYNC_FIFO_ALMOST_EN
   ,
   output logic             o_almost_full,
   output logic             o_almost_empty
`endif
);

   localparam int DEPTH = 2 ** ADDRW;
   localparam logic [ADDRW:0] PTR_ONE = {{ADDRW{1'b0}}, 1'b1};

   logic [DATAW-1:0] mem_q [DEPTH];

   logic [ADDRW:0] wr_ptr_q, wr_ptr_d;
   logic [ADDRW:0] rd_ptr_q, rd_ptr_d;
   logic [ADDRW:0] count_q, count_d;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             mem_we;
   logic [ADDRW-1:0] mem_waddr;

   // Pointers carry one extra wrap bit so equal low bits can mean either empty or full.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDRW-1:0] == rd_ptr_q[ADDRW-1:0]) &&
                  (wr_ptr_q[ADDRW] != rd_ptr_q[ADDRW]);

   assign o_wr_ready = !full;
   assign o_rd_valid = !empty;
   assign o_rd_data  = mem_q[rd_ptr_q[ADDRW-1:0]];
   assign o_count    = count_q;

   assign push = i_wr_valid && !full;
   assign pop  = i_rd_ready && !empty;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      mem_we    = 1'b0;
      mem_waddr = wr_ptr_q[ADDRW-1:0];
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         mem_we   = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + PTR_ONE;
         2'b01:   count_d = count_q - PTR_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is never cleared; stale entries stay hidden behind the reset pointers.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[mem_waddr] <= i_wr_data;
      end
   end

`ifdef SYNC_FIFO_ALMOST_EN
   localparam logic [ADDRW:0] AF_LVL = AF_LEVEL[ADDRW:0];
   localparam logic [ADDRW:0] AE_LVL = AE_LEVEL[ADDRW:0];

   logic almost_full_q, almost_full_d;
   logic almost_empty_q, almost_empty_d;

   // Flags are derived from the next count so they line up with o_count.
   always_comb begin
      almost_full_d  = (count_d >= AF_LVL);
      almost_empty_d = (count_d <= AE_LVL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
      end else begin
         almost_full_q  <= almost_full_d;
         almost_empty_q <= almost_empty_d;
      end
   end

   assign o_almost_full  = almost_full_q;
   assign o_almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed plus randomized bench for sync_fifo; expected values come from a
// queue-based model of the FIFO's observable behaviour.
module tb_sync_fifo;

   localparam int ADDRW = 4;
   localparam int DATAW = 8;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             i_wr_valid = 1'b0;
   logic             o_wr_ready;
   logic [DATAW-1:0] i_wr_data = '0;
   logic             o_rd_valid;
   logic             i_rd_ready = 1'b0;
   logic [DATAW-1:0] o_rd_data;
   logic [ADDRW:0]   o_count;
`ifdef SYNC_FIFO_ALMOST_EN
   logic             o_almost_full;
   logic             o_almost_empty;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [DATAW-1:0] exp_q[$];

   sync_fifo #(.ADDRW(ADDRW), .DATAW(DATAW)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_wr_valid (i_wr_valid),
      .o_wr_ready (o_wr_ready),
      .i_wr_data  (i_wr_data),
      .o_rd_valid (o_rd_valid),
      .i_rd_ready (i_rd_ready),
      .o_rd_data  (o_rd_data),
      .o_count    (o_count)
`ifdef SYNC_FIFO_ALMOST_EN
      ,
      .o_almost_full  (o_almost_full),
      .o_almost_empty (o_almost_empty)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = exp_q.size();
      chk({tag, ".count"}, 32'(o_count), 32'(sz));
      chk({tag, ".rd_valid"}, 32'(o_rd_valid), 32'(sz > 0));
      chk({tag, ".wr_ready"}, 32'(o_wr_ready), 32'(sz < DEPTH));
      if (sz > 0) chk({tag, ".rd_data"}, 32'(o_rd_data), 32'(exp_q[0]));
`ifdef SYNC_FIFO_ALMOST_EN
      chk({tag, ".almost_full"}, 32'(o_almost_full), 32'(sz >= DEPTH - 2));
      chk({tag, ".almost_empty"}, 32'(o_almost_empty), 32'(sz <= 2));
`endif
   endtask

   // One rising edge: apply the FIFO rules to the model, then check just after the edge.
   task automatic tick(input string tag);
      bit do_push, do_pop;
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
      end else begin
         do_push = i_wr_valid && (exp_q.size() < DEPTH);
         do_pop  = i_rd_ready && (exp_q.size() > 0);
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(i_wr_data);
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      int af_pct, rd_pct;
      // Reset state
      #12;
      chk("reset.count", 32'(o_count), 32'd0);
      chk("reset.rd_valid", 32'(o_rd_valid), 32'd0);
      chk("reset.wr_ready", 32'(o_wr_ready), 32'd1);
`ifdef SYNC_FIFO_ALMOST_EN
      chk("reset.almost_full", 32'(o_almost_full), 32'd0);
      chk("reset.almost_empty", 32'(o_almost_empty), 32'd1);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single word falls through
      i_wr_valid = 1'b1;
      i_wr_data  = 8'hA5;
      i_rd_ready = 1'b0;
      tick("first");
      chk("first.rd_valid", 32'(o_rd_valid), 32'd1);
      chk("first.rd_data", 32'(o_rd_data), 32'hA5);
      chk("first.count", 32'(o_count), 32'd1);
      i_wr_valid = 1'b0;
      i_rd_ready = 1'b1;
      tick("first_pop");
      chk("first_pop.rd_valid", 32'(o_rd_valid), 32'd0);

      // Fill to full, then one refused push
      i_rd_ready = 1'b0;
      i_wr_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         i_wr_data = 8'(i);
         tick("fill");
`ifdef SYNC_FIFO_ALMOST_EN
         if (i == 13) chk("fill14.almost_full", 32'(o_almost_full), 32'd1);
`endif
      end
      chk("full.wr_ready", 32'(o_wr_ready), 32'd0);
      chk("full.count", 32'(o_count), 32'd16);
      i_wr_data  = 8'hFF;
      i_rd_ready = 1'b1;
      i_rd_ready = 1'b0;
      tick("push17");
      chk("push17.count", 32'(o_count), 32'd16);

      // Drain in order
      i_wr_valid = 1'b0;
      i_rd_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain.rd_data", 32'(o_rd_data), 32'(i));
         tick("drain");
`ifdef SYNC_FIFO_ALMOST_EN
         if (i == 13) chk("drain2.almost_empty", 32'(o_almost_empty), 32'd1);
`endif
      end
      chk("empty.rd_valid", 32'(o_rd_valid), 32'd0);
      chk("empty.count", 32'(o_count), 32'd0);

      // Pop while empty with a simultaneous push: no read bypass
      i_wr_valid = 1'b1;
      i_wr_data  = 8'h3C;
      tick("empty_pushpop");
      chk("empty_pushpop.count", 32'(o_count), 32'd1);

      // Steady state at count 5, push and pop every cycle
      i_rd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         i_wr_data = 8'($urandom);
         tick("to5");
      end
      i_rd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         i_wr_data = 8'($urandom);
         tick("stream");
         chk("stream.count", 32'(o_count), 32'd5);
      end

      // Full with simultaneous pop: push still refused
      i_rd_ready = 1'b0;
      while (exp_q.size() < DEPTH) begin
         i_wr_data = 8'($urandom);
         tick("refill");
      end
      i_rd_ready = 1'b1;
      i_wr_data  = 8'hEE;
      tick("full_pushpop");
      chk("full_pushpop.count", 32'(o_count), 32'd15);

      // Count 7, then asynchronous reset between edges
      i_wr_valid = 1'b0;
      while (exp_q.size() > 7) tick("to7");
      chk("pre_rst.count", 32'(o_count), 32'd7);
      i_rd_ready = 1'b0;
      #3;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("async_rst.count", 32'(o_count), 32'd0);
      chk("async_rst.rd_valid", 32'(o_rd_valid), 32'd0);
      chk("async_rst.wr_ready", 32'(o_wr_ready), 32'd1);
      i_wr_valid = 1'b1;
      i_wr_data  = 8'h77;
      tick("rst_edge");
      #2;
      rst = 1'b0;
      i_wr_valid = 1'b0;
      #1;
      check_all("post_rst");

      // Randomized traffic with varying pressure
      for (int phase = 0; phase < 4; phase++) begin
         case (phase)
            0:       begin af_pct = 80; rd_pct = 20; end
            1:       begin af_pct = 20; rd_pct = 80; end
            2:       begin af_pct = 50; rd_pct = 50; end
            default: begin af_pct = 95; rd_pct = 90; end
         endcase
         for (int i = 0; i < 100; i++) begin
            i_wr_valid = ($urandom_range(0, 99) < af_pct);
            i_rd_ready = ($urandom_range(0, 99) < rd_pct);
            i_wr_data  = 8'($urandom);
            tick("random");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
